operand_fetch_unit: RTL and testbench
=====================================

// Module: operand_fetch_unit
// PURPOSE
//  Parametrised operand-fetch stage for the decode slot. Holds the architectural register file and
//  serves NUM_RD_PORTS source operands per cycle, forwarded from NUM_FWD downstream stages (0 = youngest).
//  A per-register scoreboard tracks in-flight multi-cycle producers (MUL/MULHU, loads) beyond the forward
//  window. Raises a load-use/long-latency stall and counts stall cycles.
// PARAMETERS
//  XLEN          32  datapath width
//  NUM_REGS      32  architectural registers; index width RW = $clog2(NUM_REGS); reg 0 hardwired zero
//  NUM_RD_PORTS   2  source operand ports
//  NUM_FWD        3  forwarding sources; index 0 youngest (EX), NUM_FWD-1 oldest (WB)
// PORTS
//  clk             in   1                  system clock, all state on rising edge
//  rst             in   1                  asynchronous, active-low reset
//  id_valid        in   1                  decode slot holds a valid instruction
//  id_rs_idx       in   NUM_RD_PORTS*RW    source indices, port p at [p*RW +: RW]
//  id_rs_used      in   NUM_RD_PORTS       port p is read by this instruction
//  id_rd_idx       in   RW                 destination index
//  id_rd_wr        in   1                  instruction writes rd
//  id_long         in   1                  producer result arrives only via wb (multi-cycle)
//  flush           in   1                  squash all in-flight instructions
//  fwd_valid       in   NUM_FWD            stage s holds a reg-writing instruction
//  fwd_idx         in   NUM_FWD*RW         stage s destination index
//  fwd_data_ok     in   NUM_FWD            stage s result is available this cycle
//  fwd_data        in   NUM_FWD*XLEN       stage s result
//  wb_en           in   1                  register-file write enable
//  wb_idx          in   RW                 write index
//  wb_data         in   XLEN               write data
//  rs_val          out  NUM_RD_PORTS*XLEN  resolved operands, port p at [p*XLEN +: XLEN]
//  stall           out  1                  hold decode slot this cycle
//  sb_pending      out  NUM_REGS           scoreboard bits, bit r = long producer in flight for r
//  stall_cnt       out  32                 saturating count of stalled cycles
// BEHAVIOUR
//  Reset (rst=0, async): all regfile entries 0, sb_pending 0, stall_cnt 0; outputs follow combinationally
//   (rs_val 0, stall 0).
//  Operand resolve, per port p, combinational, first match wins:
//   1. idx==0 -> 0, never stalls.
//   2. youngest s with fwd_valid[s] & fwd_idx[s]==idx: fwd_data_ok[s] ? fwd_data[s] : port stall.
//      Older matching stages are NOT consulted when the youngest match is not ready.
//   3. wb_en & wb_idx==idx -> wb_data (write-through bypass, same cycle).
//   4. sb_pending[idx] -> port stall.
//   5. regfile[idx].
//  stall = id_valid & OR over p of (id_rs_used[p] & port stall). Unused ports never stall; rs_val
//   still shows resolved value.
//  Issue = id_valid & ~stall & ~flush.
//  Regfile: write on wb_en & wb_idx!=0 at clock edge; writes to 0 ignored.
//  Scoreboard, per edge, in priority order:
//   flush -> all bits 0 (issue suppressed this cycle).
//   set bit id_rd_idx on issue & id_rd_wr & id_long & id_rd_idx!=0.
//   clear bit wb_idx on wb_en, unless same index is set this cycle (set wins: newer producer).
//   Single outstanding long producer per register: issuing a second id_long write to a pending rd is
//   legal only after its wb; decode never issues it while it is pending (rd pending counts as WAW stall,
//   included in stall).
//  stall_cnt: +1 each cycle with stall=1; holds at 32'hFFFF_FFFF.
//  Latency: operands and stall 0-cycle (combinational from inputs/state); scoreboard/regfile visible
//   the cycle after the edge.
//  Reset asserted mid-operation: immediate clear of all state regardless of pending producers.
// TESTING
//  Reset: rst=0 then 1, read x5 on port 0 -> rs_val=0, stall=0, stall_cnt=0, sb_pending=0.
//  Priority: fwd0 idx=7 data=0x11, fwd2 idx=7 data=0x33, wb idx=7 data=0x44 -> port reads 0x11;
//   drop fwd0 -> 0x33; drop fwd2 -> 0x44.
//  Load-use: fwd0 idx=3 data_ok=0, fwd1 idx=3 data_ok=1, port0 reads x3 used -> stall=1;
//   same with id_rs_used=0 -> stall=0.
//  Long op: issue MUL rd=9 id_long -> sb_pending[9]=1; reader of x9 stalls and stall_cnt increments;
//   wb_en idx=9 data=0xABCD -> bypass 0xABCD that cycle, bit cleared next cycle.
//  Simultaneous set/clear on rd=9, then flush with bits 4,9 set -> bit 9 stays 1; after flush all bits 0.
//  x0: wb_en idx=0 data=0xFFFF, fwd0 idx=0 data_ok=0 -> reads 0, no stall; force 2^32 stalls ->
//   stall_cnt saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/operand_fetch_unit.sv
// Operand-fetch stage for the decode slot: architectural register file,
// per-port forwarding from downstream stages, long-latency scoreboard,
// hazard stall generation and a saturating stall-cycle counter.
module operand_fetch_unit #(
  parameter  int unsigned XLEN         = 32,
  parameter  int unsigned NUM_REGS     = 32,
  parameter  int unsigned NUM_RD_PORTS = 2,
  parameter  int unsigned NUM_FWD      = 3,
  localparam int unsigned RW           = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [NUM_RD_PORTS*RW-1:0]   id_rs_idx,
  input  logic [NUM_RD_PORTS-1:0]      id_rs_used,
  input  logic [RW-1:0]                id_rd_idx,
  input  logic                         id_rd_wr,
  input  logic                         id_long,
  input  logic                         flush,
  input  logic [NUM_FWD-1:0]           fwd_valid,
  input  logic [NUM_FWD*RW-1:0]        fwd_idx,
  input  logic [NUM_FWD-1:0]           fwd_data_ok,
  input  logic [NUM_FWD*XLEN-1:0]      fwd_data,
  input  logic                         wb_en,
  input  logic [RW-1:0]                wb_idx,
  input  logic [XLEN-1:0]              wb_data,
  output logic [NUM_RD_PORTS*XLEN-1:0] rs_val,
  output logic                         stall,
  output logic [NUM_REGS-1:0]          sb_pending,
  output logic [31:0]                  stall_cnt
);

  logic [XLEN-1:0]         regs [NUM_REGS];
  logic [NUM_RD_PORTS-1:0] port_stall;
  logic                    waw_stall;
  logic                    issue;
  logic [NUM_REGS-1:0]     sb_next;

  // Resolve each source port: x0, youngest forward match, wb bypass, scoreboard, regfile.
  always_comb begin
    rs_val     = '0;
    port_stall = '0;
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      logic [RW-1:0]   idx;
      logic [XLEN-1:0] val;
      logic            hit;
      logic            pst;
      idx = id_rs_idx[p*RW +: RW];
      val = '0;
      hit = 1'b0;
      pst = 1'b0;
      if (idx != '0) begin
        // The youngest matching stage owns the value; older ones are never consulted.
        for (int unsigned s = 0; s < NUM_FWD; s++) begin
          if (!hit && fwd_valid[s] && (fwd_idx[s*RW +: RW] == idx)) begin
            hit = 1'b1;
            if (fwd_data_ok[s]) val = fwd_data[s*XLEN +: XLEN];
            else                pst = 1'b1;
          end
        end
        if (!hit) begin
          if (wb_en && (wb_idx == idx)) val = wb_data;
          else if (sb_pending[idx])     pst = 1'b1;
          else                          val = regs[idx];
        end
      end
      rs_val[p*XLEN +: XLEN] = val;
      port_stall[p]          = pst;
    end
  end

  // Combine port hazards with the single-outstanding-long-producer WAW rule.
  always_comb begin
    waw_stall = id_rd_wr && id_long && (id_rd_idx != '0) && sb_pending[id_rd_idx];
    stall     = id_valid && ((|(id_rs_used & port_stall)) || waw_stall);
    issue     = id_valid && !stall && !flush;
  end

  // Next scoreboard: wb clears first so a same-cycle set from a newer producer wins.
  always_comb begin
    sb_next = sb_pending;
    if (wb_en) sb_next[wb_idx] = 1'b0;
    if (issue && id_rd_wr && id_long && (id_rd_idx != '0)) sb_next[id_rd_idx] = 1'b1;
    if (flush) sb_next = '0;
  end

  // Register file write port; x0 stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (wb_en && (wb_idx != '0)) begin
      regs[wb_idx] <= wb_data;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb_pending <= '0;
    else      sb_pending <= sb_next;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            stall_cnt <= '0;
    else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: directed scenarios plus randomized traffic,
// checked by a scoreboard queue against a behavioural model of the stage.
module tb_operand_fetch_unit;

  localparam int XL = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int NF = 3;
  localparam int RW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [NP*RW-1:0]  id_rs_idx;
  logic [NP-1:0]     id_rs_used;
  logic [RW-1:0]     id_rd_idx;
  logic              id_rd_wr;
  logic              id_long;
  logic              flush;
  logic [NF-1:0]     fwd_valid;
  logic [NF*RW-1:0]  fwd_idx;
  logic [NF-1:0]     fwd_data_ok;
  logic [NF*XL-1:0]  fwd_data;
  logic              wb_en;
  logic [RW-1:0]     wb_idx;
  logic [XL-1:0]     wb_data;
  logic [NP*XL-1:0]  rs_val;
  logic              stall;
  logic [NR-1:0]     sb_pending;
  logic [31:0]       stall_cnt;

  operand_fetch_unit #(
    .XLEN(XL), .NUM_REGS(NR), .NUM_RD_PORTS(NP), .NUM_FWD(NF)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_idx(id_rs_idx),
    .id_rs_used(id_rs_used), .id_rd_idx(id_rd_idx), .id_rd_wr(id_rd_wr),
    .id_long(id_long), .flush(flush), .fwd_valid(fwd_valid), .fwd_idx(fwd_idx),
    .fwd_data_ok(fwd_data_ok), .fwd_data(fwd_data), .wb_en(wb_en),
    .wb_idx(wb_idx), .wb_data(wb_data), .rs_val(rs_val), .stall(stall),
    .sb_pending(sb_pending), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [63:0] rs;
    logic [1:0]  rs_chk;
    logic        stall;
    logic [31:0] sb;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_sb;
  logic [31:0] m_cnt;

  function automatic logic [32:0] resolve(input logic [4:0] idx);
    if (idx == 5'd0) return {1'b0, 32'h0};
    for (int s = 0; s < NF; s++)
      if (fwd_valid[s] && fwd_idx[s*RW +: RW] == idx)
        return fwd_data_ok[s] ? {1'b0, fwd_data[s*XL +: XL]} : {1'b1, 32'h0};
    if (wb_en && wb_idx == idx) return {1'b0, wb_data};
    if (m_sb[idx]) return {1'b1, 32'h0};
    return {1'b0, m_regs[idx]};
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++) m_regs[r] = 32'h0;
    m_sb  = 32'h0;
    m_cnt = 32'h0;
  endtask

  // Issue one cycle: predict outputs, queue them, then advance model across the edge.
  task automatic step(input string nm);
    exp_t        e;
    logic [32:0] r;
    logic        any;
    logic        waw;
    logic        st;
    if (!rst) model_clear();
    any = 1'b0;
    e.name = nm;
    for (int p = 0; p < NP; p++) begin
      r = resolve(id_rs_idx[p*RW +: RW]);
      e.rs[p*32 +: 32] = r[31:0];
      e.rs_chk[p]      = ~r[32];
      if (id_rs_used[p] && r[32]) any = 1'b1;
    end
    waw = id_rd_wr && id_long && id_rd_idx != 5'd0 && m_sb[id_rd_idx];
    st  = id_valid && (any || waw);
    e.stall = st;
    e.sb    = m_sb;
    e.cnt   = m_cnt;
    q.push_back(e);
    @(posedge clk);
    if (rst) begin
      if (wb_en && wb_idx != 5'd0) m_regs[wb_idx] = wb_data;
      if (flush) m_sb = 32'h0;
      else begin
        if (wb_en) m_sb[wb_idx] = 1'b0;
        if (id_valid && !st && id_rd_wr && id_long && id_rd_idx != 5'd0) m_sb[id_rd_idx] = 1'b1;
      end
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs_idx = '0; id_rs_used = '0; id_rd_idx = '0;
    id_rd_wr = 0; id_long = 0; flush = 0; fwd_valid = '0; fwd_idx = '0;
    fwd_data_ok = '0; fwd_data = '0; wb_en = 0; wb_idx = '0; wb_data = '0;
  endtask

  task automatic set_fwd(input int s, input logic v, input logic [4:0] idx,
                         input logic ok, input logic [31:0] d);
    fwd_valid[s] = v;
    fwd_idx[s*RW +: RW] = idx;
    fwd_data_ok[s] = ok;
    fwd_data[s*XL +: XL] = d;
  endtask

  task automatic read0(input logic [4:0] idx, input logic used);
    id_valid = 1; id_rs_idx[4:0] = idx; id_rs_used[0] = used;
  endtask

  // Monitor: compare DUT outputs against queued expectations on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int p = 0; p < NP; p++) begin
          if (e.rs_chk[p]) begin
            checks++;
            if (rs_val[p*XL +: XL] !== e.rs[p*32 +: 32]) begin
              errors++;
              $display("FAIL %s rs_val[%0d] got %h exp %h", e.name, p, rs_val[p*XL +: XL], e.rs[p*32 +: 32]);
            end
          end
        end
        checks++;
        if (stall !== e.stall) begin
          errors++;
          $display("FAIL %s stall got %b exp %b", e.name, stall, e.stall);
        end
        checks++;
        if (sb_pending !== e.sb) begin
          errors++;
          $display("FAIL %s sb_pending got %h exp %h", e.name, sb_pending, e.sb);
        end
        checks++;
        if (stall_cnt !== e.cnt) begin
          errors++;
          $display("FAIL %s stall_cnt got %h exp %h", e.name, stall_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 0;
    model_clear();
    @(posedge clk); #1;

    // Reset
    read0(5'd5, 1'b1);
    step("reset_held");
    rst = 1;
    step("reset_read_x5");

    // Forwarding priority
    idle();
    read0(5'd7, 1'b1);
    set_fwd(0, 1, 5'd7, 1, 32'h11);
    set_fwd(2, 1, 5'd7, 1, 32'h33);
    wb_en = 1; wb_idx = 5'd7; wb_data = 32'h44;
    step("prio_fwd0");
    set_fwd(0, 0, 5'd7, 1, 32'h11);
    step("prio_fwd2");
    set_fwd(2, 0, 5'd7, 1, 32'h33);
    step("prio_wb");

    // Load-use
    idle();
    read0(5'd3, 1'b1);
    set_fwd(0, 1, 5'd3, 0, 32'h55);
    set_fwd(1, 1, 5'd3, 1, 32'h66);
    step("loaduse_used");
    id_rs_used = '0;
    step("loaduse_unused");

    // Long-latency producer
    idle();
    id_valid = 1; id_rd_idx = 5'd9; id_rd_wr = 1; id_long = 1;
    step("long_issue");
    idle();
    read0(5'd9, 1'b1);
    step("long_read_stall1");
    step("long_read_stall2");
    wb_en = 1; wb_idx = 5'd9; wb_data = 32'hABCD;
    step("long_wb_bypass");
    wb_en = 0;
    step("long_after_wb");

    // WAW: second long write to pending rd stalls
    idle();
    id_valid = 1; id_rd_idx = 5'd9; id_rd_wr = 1; id_long = 1;
    step("waw_first");
    step("waw_second");
    wb_en = 1; wb_idx = 5'd9; wb_data = 32'h1234;
    id_valid = 0;
    step("waw_release");

    // Simultaneous set/clear and flush
    idle();
    id_valid = 1; id_rd_idx = 5'd4; id_rd_wr = 1; id_long = 1;
    step("setclr_rd4");
    wb_en = 1; wb_idx = 5'd9; wb_data = 32'h77; id_rd_idx = 5'd9;
    step("setclr_rd9");
    wb_en = 0; id_rd_idx = 5'd5; flush = 1;
    step("flush");
    idle();
    step("after_flush");

    // x0 handling
    read0(5'd0, 1'b1);
    wb_en = 1; wb_idx = 5'd0; wb_data = 32'hFFFF;
    set_fwd(0, 1, 5'd0, 0, 32'h99);
    step("x0_bypass");
    idle();
    read0(5'd0, 1'b1);
    step("x0_regfile");

    // Counter saturation
    idle();
    force dut.stall_cnt = 32'hFFFF_FFFD;
    release dut.stall_cnt;
    m_cnt = 32'hFFFF_FFFD;
    read0(5'd3, 1'b1);
    set_fwd(0, 1, 5'd3, 0, 32'h0);
    for (int i = 0; i < 5; i++) step("cnt_saturate");

    // Mid-operation reset with a pending producer
    idle();
    id_valid = 1; id_rd_idx = 5'd12; id_rd_wr = 1; id_long = 1;
    step("prereset_issue");
    idle();
    rst = 0;
    step("midop_reset");
    rst = 1;
    step("post_reset");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom_range(0, 299) != 0);
      id_valid    = $urandom_range(0, 3) != 0;
      for (int p = 0; p < NP; p++) id_rs_idx[p*RW +: RW] = 5'($urandom_range(0, 7));
      id_rs_used  = 2'($urandom);
      id_rd_idx   = 5'($urandom_range(0, 7));
      id_rd_wr    = $urandom_range(0, 3) != 0;
      id_long     = $urandom_range(0, 2) == 0;
      flush       = $urandom_range(0, 19) == 0;
      for (int s = 0; s < NF; s++)
        set_fwd(s, 1'($urandom), 5'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0, $urandom);
      wb_en       = 1'($urandom);
      wb_idx      = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      step("random");
    end

    idle();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain queue_left got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
